// File: rtl/tone_mixer_pkg.sv
// Shared types and helpers for the multi-voice tone mixer.
// Holds the duty-mode encodings, FSM states, default widths and the signed clamp.
package tone_mixer_pkg;

  localparam int SAMPLE_W_DEF = 32;
  localparam int ACC_GUARD    = 4;

  typedef enum logic [1:0] {
    MODE_HALF     = 2'b00,
    MODE_QUARTER  = 2'b01,
    MODE_EIGHTH   = 2'b10,
    MODE_HALF_ALT = 2'b11
  } duty_mode_e;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } mix_state_e;

  // Clamp a signed value to the range of a signed w-bit number; caller truncates to w bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi_v;
    logic signed [63:0] lo_v;
    logic signed [63:0] res_v;
    hi_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo_v = -hi_v - 64'sd1;
    if (v > hi_v) begin
      res_v = hi_v;
    end else if (v < lo_v) begin
      res_v = lo_v;
    end else begin
      res_v = v;
    end
    return res_v;
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One pulse oscillator: phase counter, duty compare and a signed +/-amp contribution.
// Inactive voices (disabled or period below 2) hold phase 0 and contribute nothing.
module tone_voice
  import tone_mixer_pkg::*;
#(
  parameter int PERIOD_W = 19,
  parameter int AMP_W    = 24,
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [PERIOD_W-1:0]        period,
  input  logic [AMP_W-1:0]           amp,
  input  logic [1:0]                 mode,
  output logic signed [SAMPLE_W-1:0] contrib
);

  logic [PERIOD_W-1:0]        cnt_r;
  logic [PERIOD_W-1:0]        thresh_s;
  logic                       active_s;
  logic                       high_s;
  logic signed [SAMPLE_W-1:0] amp_ext_s;

  assign active_s  = en && (period >= PERIOD_W'(2));
  assign amp_ext_s = $signed({{(SAMPLE_W-AMP_W){1'b0}}, amp});

  // Duty threshold and signed contribution from the current phase.
  always_comb begin
    thresh_s = period >> 1;
    case (duty_mode_e'(mode))
      MODE_HALF:     thresh_s = period >> 1;
      MODE_QUARTER:  thresh_s = period >> 2;
      MODE_EIGHTH:   thresh_s = period >> 3;
      MODE_HALF_ALT: thresh_s = period >> 1;
      default:       thresh_s = period >> 1;
    endcase
    high_s = (cnt_r < thresh_s);
    if (!active_s) begin
      contrib = '0;
    end else if (high_s) begin
      contrib = amp_ext_s;
    end else begin
      contrib = -amp_ext_s;
    end
  end

  // Phase counter; the >= compare lets a shortened period wrap at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (!active_s) begin
      cnt_r <= '0;
    end else if (cnt_r >= (period - PERIOD_W'(1))) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/tone_mixer.sv
// Multi-voice tone synthesiser: voices are summed one per cycle into saturated
// left/right mix registers, which are added with saturation to the codec input.
module tone_mixer
  import tone_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 19,
  parameter int AMP_W      = 24,
  parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic [NUM_VOICES-1:0]          voice_en,
  input  logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
  input  logic [NUM_VOICES*AMP_W-1:0]    voice_amp,
  input  logic [NUM_VOICES*2-1:0]        voice_mode,
  input  logic [NUM_VOICES*2-1:0]        voice_pan,
  input  logic                           audio_in_available,
  input  logic                           audio_out_allowed,
  input  logic [SAMPLE_W-1:0]            left_channel_audio_in,
  input  logic [SAMPLE_W-1:0]            right_channel_audio_in,
  output logic                           read_audio_in,
  output logic                           write_audio_out,
  output logic [SAMPLE_W-1:0]            left_channel_audio_out,
  output logic [SAMPLE_W-1:0]            right_channel_audio_out
);

  localparam int ACC_W = SAMPLE_W + ACC_GUARD;
  localparam int KW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic signed [SAMPLE_W-1:0] contrib_s [NUM_VOICES];
  logic [1:0]                 pan_s     [NUM_VOICES];

  mix_state_e             state_r, state_nxt_s;
  logic [KW-1:0]          k_r, k_nxt_s;
  logic signed [ACC_W-1:0]    acc_l_r, acc_r_r, acc_l_nxt_s, acc_r_nxt_s;
  logic signed [SAMPLE_W-1:0] mix_l_r, mix_r_r, mix_l_nxt_s, mix_r_nxt_s;
  logic signed [ACC_W-1:0]    sel_ext_s;
  logic [1:0]                 sel_pan_s;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : gen_voice
    tone_voice #(
      .PERIOD_W (PERIOD_W),
      .AMP_W    (AMP_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_voice (
      .clk     (CLOCK_50),
      .reset   (reset),
      .en      (voice_en[i]),
      .period  (voice_period[i*PERIOD_W +: PERIOD_W]),
      .amp     (voice_amp[i*AMP_W +: AMP_W]),
      .mode    (voice_mode[i*2 +: 2]),
      .contrib (contrib_s[i])
    );
    assign pan_s[i] = voice_pan[i*2 +: 2];
  end

  // Mix FSM: ACC adds voice k to the panned accumulators, DONE publishes the clamped mix.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    acc_l_nxt_s = acc_l_r;
    acc_r_nxt_s = acc_r_r;
    mix_l_nxt_s = mix_l_r;
    mix_r_nxt_s = mix_r_r;
    sel_ext_s   = ACC_W'(contrib_s[k_r]);
    sel_pan_s   = pan_s[k_r];
    case (state_r)
      ST_ACC: begin
        if (sel_pan_s[1]) begin
          acc_l_nxt_s = acc_l_r + sel_ext_s;
        end else begin
          acc_l_nxt_s = acc_l_r;
        end
        if (sel_pan_s[0]) begin
          acc_r_nxt_s = acc_r_r + sel_ext_s;
        end else begin
          acc_r_nxt_s = acc_r_r;
        end
        if (k_r == KW'(NUM_VOICES - 1)) begin
          state_nxt_s = ST_DONE;
        end else begin
          k_nxt_s = k_r + KW'(1);
        end
      end
      ST_DONE: begin
        mix_l_nxt_s = SAMPLE_W'(sat(64'(acc_l_r), SAMPLE_W));
        mix_r_nxt_s = SAMPLE_W'(sat(64'(acc_r_r), SAMPLE_W));
        acc_l_nxt_s = '0;
        acc_r_nxt_s = '0;
        k_nxt_s     = '0;
        state_nxt_s = ST_ACC;
      end
      default: begin
        acc_l_nxt_s = '0;
        acc_r_nxt_s = '0;
        k_nxt_s     = '0;
        state_nxt_s = ST_ACC;
      end
    endcase
  end

  // Mix FSM state, voice index, accumulators and mix registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= ST_ACC;
      k_r     <= '0;
      acc_l_r <= '0;
      acc_r_r <= '0;
      mix_l_r <= '0;
      mix_r_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      acc_l_r <= acc_l_nxt_s;
      acc_r_r <= acc_r_nxt_s;
      mix_l_r <= mix_l_nxt_s;
      mix_r_r <= mix_r_nxt_s;
    end
  end

  // Passthrough plus mix, clamped so a loud tone never wraps the codec sample.
  always_comb begin
    left_channel_audio_out  = SAMPLE_W'(sat(64'($signed(left_channel_audio_in))
                                            + 64'(mix_l_r), SAMPLE_W));
    right_channel_audio_out = SAMPLE_W'(sat(64'($signed(right_channel_audio_in))
                                            + 64'(mix_r_r), SAMPLE_W));
    read_audio_in   = audio_in_available & audio_out_allowed & ~reset;
    write_audio_out = audio_in_available & audio_out_allowed & ~reset;
  end

endmodule

// File: tb/tb_tone_mixer.sv
// Directed self-checking bench for tone_mixer: tones, duty modes, saturation,
// handshake, reset and period-shortening behaviour, with hand-computed expectations.
module tb_tone_mixer;

  localparam int NV = 4;
  localparam int PW = 19;
  localparam int AW = 24;
  localparam int SW = 32;

  logic                 CLOCK_50;
  logic                 reset;
  logic [NV-1:0]        voice_en;
  logic [NV*PW-1:0]     voice_period;
  logic [NV*AW-1:0]     voice_amp;
  logic [NV*2-1:0]      voice_mode;
  logic [NV*2-1:0]      voice_pan;
  logic                 audio_in_available;
  logic                 audio_out_allowed;
  logic [SW-1:0]        left_channel_audio_in;
  logic [SW-1:0]        right_channel_audio_in;
  logic                 read_audio_in;
  logic                 write_audio_out;
  logic [SW-1:0]        left_channel_audio_out;
  logic [SW-1:0]        right_channel_audio_out;

  int n_checks = 0;
  int n_pass   = 0;
  int high_cnt;

  tone_mixer #(
    .NUM_VOICES (NV),
    .PERIOD_W   (PW),
    .AMP_W      (AW),
    .SAMPLE_W   (SW)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .voice_en                (voice_en),
    .voice_period            (voice_period),
    .voice_amp               (voice_amp),
    .voice_mode              (voice_mode),
    .voice_pan               (voice_pan),
    .audio_in_available      (audio_in_available),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .read_audio_in           (read_audio_in),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic set_voice(input int i, input logic en, input int per, input int amp,
                           input logic [1:0] mode, input logic [1:0] pan);
    voice_en[i]                 = en;
    voice_period[i*PW +: PW]    = PW'(per);
    voice_amp[i*AW +: AW]       = AW'(amp);
    voice_mode[i*2 +: 2]        = mode;
    voice_pan[i*2 +: 2]         = pan;
  endtask

  task automatic clear_voices();
    voice_en     = '0;
    voice_period = '0;
    voice_amp    = '0;
    voice_mode   = '0;
    voice_pan    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    reset                  = 1'b1;
    clear_voices();
    audio_in_available     = 1'b1;
    audio_out_allowed      = 1'b1;
    left_channel_audio_in  = 32'sd123;
    right_channel_audio_in = -32'sd7;
    tick(2);

    // Reset: strobes low, output is pure passthrough
    chk("rst_read", read_audio_in, 0);
    chk("rst_write", write_audio_out, 0);
    chk("rst_left", $signed(left_channel_audio_out), 123);
    chk("rst_right", $signed(right_channel_audio_out), -7);

    // 1: single square voice, period 100, amp 1000, both channels
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    set_voice(0, 1'b1, 100, 1000, 2'b00, 2'b11);
    reset = 1'b0;
    tick(25);
    chk("t1_l_hi", $signed(left_channel_audio_out), 1000);
    chk("t1_r_hi", $signed(right_channel_audio_out), 1000);
    tick(55);
    chk("t1_l_lo", $signed(left_channel_audio_out), -1000);
    chk("t1_r_lo", $signed(right_channel_audio_out), -1000);
    tick(50);
    chk("t1_l_wrap", $signed(left_channel_audio_out), 1000);
    chk("t1_r_wrap", $signed(right_channel_audio_out), 1000);

    // 2: duty modes measured on the oscillator over one full period
    voice_mode[1:0] = 2'b01;
    tick(1);
    high_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (dut.gen_voice[0].u_voice.contrib > 0) high_cnt++;
      tick(1);
    end
    chk("t2_duty25", high_cnt, 25);
    voice_mode[1:0] = 2'b10;
    tick(1);
    high_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (dut.gen_voice[0].u_voice.contrib > 0) high_cnt++;
      tick(1);
    end
    chk("t2_duty12", high_cnt, 12);

    // 3: four full-scale voices to the left saturate the output
    do_reset();
    for (int i = 0; i < NV; i++) set_voice(i, 1'b1, 1000, 8388607, 2'b00, 2'b10);
    left_channel_audio_in  = 32'sd2130706432;
    right_channel_audio_in = 32'sd555;
    reset = 1'b0;
    tick(20);
    chk("t3_left_sat", $signed(left_channel_audio_out), 2147483647);
    chk("t3_right_pass", $signed(right_channel_audio_out), 555);
    left_channel_audio_in = '0;
    #1;
    chk("t3_left_mix", $signed(left_channel_audio_out), 33554428);

    // 4: negative saturation; period 2 in mode 10 keeps the voice low
    do_reset();
    clear_voices();
    set_voice(0, 1'b1, 2, 500, 2'b10, 2'b11);
    left_channel_audio_in  = 32'h8000_0000;
    right_channel_audio_in = 32'sd1000;
    reset = 1'b0;
    tick(10);
    chk("t4_left_neg_sat", $signed(left_channel_audio_out), -64'sd2147483648);
    chk("t4_right_sum", $signed(right_channel_audio_out), 500);
    voice_period[PW-1:0] = PW'(1);
    tick(1);
    chk("t4_short_contrib", dut.gen_voice[0].u_voice.contrib, 0);
    chk("t4_short_cnt", dut.gen_voice[0].u_voice.cnt_r, 0);
    voice_period[PW-1:0] = PW'(100);
    voice_en[0] = 1'b0;
    tick(1);
    chk("t4_dis_contrib", dut.gen_voice[0].u_voice.contrib, 0);

    // 5: handshake strobes need both flags and no reset
    audio_in_available = 1'b1;
    for (int c = 0; c < 4; c++) begin
      audio_out_allowed = c[0];
      #1;
      chk("t5_read", read_audio_in, c[0]);
      chk("t5_write", write_audio_out, c[0]);
      tick(1);
    end
    audio_in_available = 1'b0;
    audio_out_allowed  = 1'b1;
    #1;
    chk("t5_noavail", read_audio_in, 0);
    audio_in_available = 1'b1;
    reset = 1'b1;
    #1;
    chk("t5_rst_read", read_audio_in, 0);
    chk("t5_rst_write", write_audio_out, 0);

    // 6: reset in the middle of accumulation
    tick(2);
    clear_voices();
    set_voice(0, 1'b1, 100, 1000, 2'b00, 2'b11);
    left_channel_audio_in  = '0;
    right_channel_audio_in = '0;
    reset = 1'b0;
    tick(12);
    chk("t6_pre_k", dut.k_r, 2);
    chk("t6_pre_mix", $signed(left_channel_audio_out), 1000);
    reset = 1'b1;
    tick(1);
    chk("t6_mix_clr", $signed(left_channel_audio_out), 0);
    chk("t6_k_clr", dut.k_r, 0);
    chk("t6_cnt_clr", dut.gen_voice[0].u_voice.cnt_r, 0);

    // 6b: period shortened below the running phase wraps on the next cycle
    voice_period[PW-1:0] = PW'(1000);
    tick(1);
    reset = 1'b0;
    tick(500);
    chk("t6_cnt500", dut.gen_voice[0].u_voice.cnt_r, 500);
    voice_period[PW-1:0] = PW'(10);
    tick(1);
    chk("t6_wrap0", dut.gen_voice[0].u_voice.cnt_r, 0);
    tick(1);
    chk("t6_wrap1", dut.gen_voice[0].u_voice.cnt_r, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
